// File: rtl/cmp_pkg.sv
// Shared definitions for the comparator window monitor: parameter
// defaults, counter-width helper and the FSM state encoding.
package cmp_pkg;

    localparam int CMP_WIDTH_DEF  = 4;
    localparam int CMP_WINDOW_DEF = 8;

    // Width needed to hold a count in 0..window inclusive.
    function automatic int cnt_w(input int window);
        return $clog2(window + 1);
    endfunction

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } cmp_state_e;

endpackage

// File: rtl/cmp_ref_check.sv
// Reference check of one comparator sample: flags err when the result
// flags are not exactly the one-hot outcome of an unsigned compare of a, b.
module cmp_ref_check #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             lt,
    input  logic             eq,
    input  logic             gt,
    output logic             err
);

    logic ref_lt;
    logic ref_eq;
    logic ref_gt;

    // The reference compare is always one-hot, so matching all three flags
    // covers both the "not exactly one flag" and "wrong flag" cases.
    always_comb begin
        ref_lt = (a < b);
        ref_eq = (a == b);
        ref_gt = (a > b);
        err    = ({lt, eq, gt} != {ref_lt, ref_eq, ref_gt});
    end

endmodule

// File: rtl/cmp_window_monitor.sv
// Window monitor: classifies WINDOW accepted comparator samples into
// lt/eq/gt/error counts and offers the totals as one report.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. in_ready is low only in REPORT (and while rst is high);
// out_valid is high only in REPORT and the report holds until out_ready.
module cmp_window_monitor
    import cmp_pkg::*;
#(
    parameter int WIDTH  = CMP_WIDTH_DEF,
    parameter int WINDOW = CMP_WINDOW_DEF,
    localparam int CNT_W = cnt_w(WINDOW)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             lt,
    input  logic             eq,
    input  logic             gt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_flag,
    output cmp_state_e       state_dbg
);

    cmp_state_e       state;
    logic [CNT_W-1:0] acc_cnt;
    logic             sample_err;
    logic             accept;

    cmp_ref_check #(.WIDTH(WIDTH)) u_ref_check (
        .a   (a),
        .b   (b),
        .lt  (lt),
        .eq  (eq),
        .gt  (gt),
        .err (sample_err)
    );

    // Handshake and status outputs decoded from the registered state; rst
    // gates in_ready so nothing is accepted while reset is held.
    always_comb begin
        in_ready  = !rst && (state != REPORT);
        out_valid = (state == REPORT);
        accept    = in_valid && in_ready;
        err_flag  = (err_cnt != '0);
        state_dbg = state;
    end

    // FSM plus counters. acc_cnt tracks accepted samples so the window
    // closes on the WINDOW-th accept; no count can exceed WINDOW.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            acc_cnt <= '0;
            lt_cnt  <= '0;
            eq_cnt  <= '0;
            gt_cnt  <= '0;
            err_cnt <= '0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc_cnt <= acc_cnt + CNT_W'(1);
                        if (sample_err)
                            err_cnt <= err_cnt + CNT_W'(1);
                        else if (lt)
                            lt_cnt <= lt_cnt + CNT_W'(1);
                        else if (eq)
                            eq_cnt <= eq_cnt + CNT_W'(1);
                        else
                            gt_cnt <= gt_cnt + CNT_W'(1);
                        if (acc_cnt == CNT_W'(WINDOW - 1))
                            state <= REPORT;
                        else
                            state <= ACCUM;
                    end
                end
                REPORT: begin
                    // Report consumed: start a fresh window from zero.
                    if (out_ready) begin
                        state   <= IDLE;
                        acc_cnt <= '0;
                        lt_cnt  <= '0;
                        eq_cnt  <= '0;
                        gt_cnt  <= '0;
                        err_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_window_monitor.sv
// Bench for cmp_window_monitor: directed windows with hand-computed
// reports, a scoreboard queue drained by a monitor on report handshakes.
module tb_cmp_window_monitor;
    import cmp_pkg::*;

    localparam int W  = 4;
    localparam int CW = cnt_w(8);
    localparam int RW = 4 * CW + 1;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         lt;
        logic         eq;
        logic         gt;
    } sample_t;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          lt = 1'b0;
    logic          eq = 1'b0;
    logic          gt = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [CW-1:0] lt_cnt;
    logic [CW-1:0] eq_cnt;
    logic [CW-1:0] gt_cnt;
    logic [CW-1:0] err_cnt;
    logic          err_flag;
    cmp_state_e    state_dbg;

    cmp_window_monitor dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .lt        (lt),
        .eq        (eq),
        .gt        (gt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .lt_cnt    (lt_cnt),
        .eq_cnt    (eq_cnt),
        .gt_cnt    (gt_cnt),
        .err_cnt   (err_cnt),
        .err_flag  (err_flag),
        .state_dbg (state_dbg)
    );

    int checks = 0;
    int passed = 0;
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] mon_exp;

    sample_t s_gt  [8];
    sample_t s_mix [8];
    sample_t s_err [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [RW-1:0] pk(input int l, input int e, input int g, input int r, input logic f);
        return {CW'(l), CW'(e), CW'(g), CW'(r), f};
    endfunction

    function automatic logic [RW-1:0] dut_report();
        return {lt_cnt, eq_cnt, gt_cnt, err_cnt, err_flag};
    endfunction

    // scoreboard monitor: compare every report handshake against the queue
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_report", 32'd1, 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("report", 32'(dut_report()), 32'(mon_exp));
            end
        end
    end

    // driver: present one sample and hold it until accepted (bounded)
    task automatic send(input sample_t s);
        int waited = 0;
        a = s.a; b = s.b; lt = s.lt; eq = s.eq; gt = s.gt;
        in_valid = 1'b1;
        while (!in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_window(input sample_t s[8], input int gap, input logic [RW-1:0] exp);
        exp_q.push_back(exp);
        for (int i = 0; i < 8; i++) begin
            send(s[i]);
            if (i < 7) repeat (gap) begin @(posedge clk); #1; end
            if (i == 6) check("no_valid_mid_window", 32'(out_valid), 32'd0);
        end
        check("valid_latency", 32'(out_valid), 32'd1);
        check("ready_low_in_report", 32'(in_ready), 32'd0);
        if (out_ready) begin
            @(posedge clk); #1;
            check("ready_after_handshake", 32'(in_ready), 32'd1);
            check("valid_low_after_handshake", 32'(out_valid), 32'd0);
            check("counts_cleared", 32'(dut_report()), 32'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            s_gt[i] = '{a: 4'd5, b: 4'd3, lt: 1'b0, eq: 1'b0, gt: 1'b1};
            if (i < 3)      s_mix[i] = '{a: 4'd2,  b: 4'd9, lt: 1'b1, eq: 1'b0, gt: 1'b0};
            else if (i < 5) s_mix[i] = '{a: 4'd7,  b: 4'd7, lt: 1'b0, eq: 1'b1, gt: 1'b0};
            else            s_mix[i] = '{a: 4'd15, b: 4'd0, lt: 1'b0, eq: 1'b0, gt: 1'b1};
            s_err[i] = '{a: 4'd6, b: 4'd6, lt: 1'b0, eq: 1'b1, gt: 1'b0};
        end
        s_err[1] = '{a: 4'd1, b: 4'd2, lt: 1'b1, eq: 1'b0, gt: 1'b1};
        s_err[3] = '{a: 4'd4, b: 4'd4, lt: 1'b0, eq: 1'b0, gt: 1'b1};

        // reset state while rst held
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_counts", 32'(dut_report()), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        #12 rst = 1'b0;
        #1 check("in_ready_after_rst", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // all-gt window, out_ready already high
        run_window(s_gt, 0, pk(0, 0, 8, 0, 1'b0));
        // mixed window
        run_window(s_mix, 0, pk(3, 2, 3, 0, 1'b0));
        // two erroneous samples among eq samples
        run_window(s_err, 0, pk(0, 6, 0, 2, 1'b1));

        // backpressure: report held for 10 cycles
        out_ready = 1'b0;
        run_window(s_mix, 0, pk(3, 2, 3, 0, 1'b0));
        repeat (10) begin
            @(posedge clk); #1;
            check("bp_valid_hold", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_counts_hold", 32'(dut_report()), 32'(pk(3, 2, 3, 0, 1'b0)));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        check("bp_release_valid", 32'(out_valid), 32'd0);

        // gaps of 3 idle cycles between samples
        run_window(s_mix, 3, pk(3, 2, 3, 0, 1'b0));

        // reset after 5 accepted samples discards the partial window
        for (int i = 0; i < 5; i++) send(s_err[i]);
        check("partial_counts", 32'(dut_report()), 32'(pk(0, 3, 0, 2, 1'b1)));
        check("partial_no_valid", 32'(out_valid), 32'd0);
        rst = 1'b1;
        #1;
        check("midrst_counts", 32'(dut_report()), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        #5 rst = 1'b0;
        #1 check("midrst_ready_after", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        run_window(s_gt, 0, pk(0, 0, 8, 0, 1'b0));

        repeat (3) @(posedge clk);
        #1 check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
